// File: rtl/dec3to8_buf.sv
// Buffered 3-to-8 decoder: queues 3-bit codes in a small FIFO and presents the
// head entry as a one-hot byte behind a valid/ready handshake.
module dec3to8_buf #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          EN,
  input  logic [2:0]    Y,
  input  logic          Y_valid,
  output logic          Y_ready,
  output logic [7:0]    Dout,
  output logic          Dout_valid,
  input  logic          Dout_ready,
  output logic [AW:0]   count,
  output logic          ovf
);

  localparam int unsigned CW = AW + 1;

  logic [2:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Handshake is derived from registered occupancy; EN low hides the queue.
  always_comb begin
    w_full     = (r_count == CW'(DEPTH));
    w_empty    = (r_count == CW'(0));
    Y_ready    = EN && !w_full;
    Dout_valid = EN && !w_empty;
    w_push     = Y_valid && Y_ready;
    w_pop      = Dout_valid && Dout_ready;
    Dout       = Dout_valid ? (8'b1 << r_mem[r_rd_ptr]) : 8'h00;
  end

  // Storage needs no reset: an entry is only observed after it is written.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= Y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Sticky until reset; the offered code is simply not written.
      if (EN && Y_valid && w_full) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;

endmodule
